level_fifo: RTL

LEVEL_FIFO -- requirements
Module: level_fifo

---
 rtl/level_fifo_if.sv | 30 +++
 rtl/level_fifo.sv | 85 ++++++++
 2 files changed

// File: rtl/level_fifo_if.sv
// Handshake and status bundle for level_fifo; master = user side, slave = FIFO side.
interface level_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH + 1);

  logic                  write;
  logic [DATA_WIDTH-1:0] datain;
  logic                  read;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  val;
  logic                  full;
  logic [LW-1:0]         level;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write, datain, read, err_clr,
    input  dataout, val, full, level, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  write, datain, read, err_clr,
    output dataout, val, full, level, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/level_fifo.sv
// Occupancy-tracked FWFT FIFO; sticky overflow/underflow only with LEVEL_FIFO_ERR_EN.
// Latency: write to dataout/val 1 cycle. Backpressure: writes dropped while full, reads ignored while empty.
module level_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic         clk,
  input  logic         reset,
  level_fifo_if.slave  bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  full_w;
  logic                  val_w;
  logic                  wr_ok;
  logic                  rd_ok;

  // All status flags come from level_q alone, so no request input reaches an output.
  assign full_w = (level_q == LW'(DEPTH));
  assign val_w  = (level_q != '0);
  assign wr_ok  = bus.write & ~full_w;
  assign rd_ok  = bus.read & val_w;

  assign bus.full         = full_w;
  assign bus.val          = val_w;
  assign bus.level        = level_q;
  assign bus.almost_full  = (level_q >= LW'(AFULL_LVL));
  assign bus.almost_empty = (level_q <= LW'(AEMPTY_LVL));
  assign bus.dataout      = mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.datain;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef LEVEL_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Clear wins over a coincident new error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.err_clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.write & full_w) ovf_q <= 1'b1;
      if (bus.read & ~val_w)  unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif
endmodule
